arr_stim: RTL

- Stimulus driver for the `arr` equality checker: drives its `sig0`/`sig1` pair with a pseudo-random vector stream, one vector per clock.
- Can force exactly one deliberate mismatch so the bench exercises the checker's error path.
- Sits beside each `arr` instance in `duv`, clocked by the `sim_ctrl` clock, with reset from `sim_ctrl`.
- Started by a one-cycle request; reports completion with a one-cycle done pulse.

---
 rtl/arr_stim_pkg.sv | 21 ++
 rtl/arr_stim_lfsr.sv | 48 ++++
 rtl/arr_stim.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/arr_stim_pkg.sv
// arr_stim_pkg: shared types and constants for the arr_stim stimulus driver.
// Build option: ARR_STIM_WALK_EN selects the walking-one pattern instead of the LFSR.
package arr_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          LFSR_W    = 32;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam int          CNT_W     = 16;
    localparam int          REP       = 8;

    // One Galois right-shift step of the pattern generator.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

endpackage

// File: rtl/arr_stim_lfsr.sv
// arr_stim_lfsr: 32-bit Galois LFSR that exposes its next value already
// replicated out to OUT_W bits, so the caller registers it directly.
// Left out of the build when ARR_STIM_WALK_EN is defined.
module arr_stim_lfsr
    import arr_stim_pkg::*;
#(
    parameter int                OUT_W = 1,
    parameter logic [LFSR_W-1:0] SEED  = 32'h0000_0001
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              adv_i,
    output logic [OUT_W-1:0]  next_pat_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] step;

    assign step = lfsr_step(lfsr_q);

    // Reload takes priority over advancing; otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_i;
        end else if (adv_i) begin
            lfsr_d = step;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Output bit gi is the next value repeated every LFSR_W bits.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_rep
        assign next_pat_o[gi] = step[gi % LFSR_W];
    end

endmodule

// File: rtl/arr_stim.sv
// arr_stim: drives the sig0/sig1 pair of an arr checker with N vectors,
// one per clock, optionally corrupting bit 0 of sig1 on one chosen vector.
// Build option: ARR_STIM_WALK_EN replaces the LFSR pattern with a walking one.
module arr_stim
    import arr_stim_pkg::*;
#(
    parameter int                LENGTH = 1,
    parameter logic [LFSR_W-1:0] SEED   = 32'h0000_0001
) (
    input  logic              arr_stim_clk_ip,
    input  logic              arr_stim_rst_ip,
    input  logic              arr_stim_start_ip,
    input  logic [CNT_W-1:0]  arr_stim_count_ip,
    input  logic [CNT_W-1:0]  arr_stim_inject_ip,
    output logic [LENGTH-1:0] arr_stim_sig0_op,
    output logic [LENGTH-1:0] arr_stim_sig1_op,
    output logic              arr_stim_busy_op,
    output logic              arr_stim_done_op,
    output logic [CNT_W-1:0]  arr_stim_sent_op
);

    localparam logic [LENGTH-1:0] BIT0 = LENGTH'(1);

    if (LENGTH < 1 || LENGTH > REP * LFSR_W - 1) begin : g_len_chk
        $error("EXM_ERROR: arr_stim LENGTH must be 1..255");
    end

    state_e             state_q, state_d;
    logic [LENGTH-1:0]  sig0_q, sig0_d;
    logic [LENGTH-1:0]  sig1_q, sig1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   inject_q, inject_d;

    logic               load;
    logic               vec_go;
    logic [CNT_W-1:0]   vec_n;
    logic [LENGTH-1:0]  pattern;

    // A start in IDLE rearms the generator; a vector is due while sent < count.
    assign load   = (state_q == ST_IDLE) && arr_stim_start_ip;
    assign vec_go = (state_q == ST_RUN) && (sent_q < count_q);
    assign vec_n  = sent_q + CNT_W'(1);

`ifdef ARR_STIM_WALK_EN
    logic [LENGTH-1:0] walk_q, walk_d;

    assign pattern = walk_q;

    // Rotate the one-hot left on every driven vector; restart at bit 0 on start.
    always_comb begin
        walk_d = walk_q;
        if (load) begin
            walk_d = BIT0;
        end else if (vec_go) begin
            walk_d = (walk_q << 1) | (walk_q >> (LENGTH - 1));
        end
    end

    // Walking-one position register.
    always_ff @(posedge arr_stim_clk_ip or posedge arr_stim_rst_ip) begin
        if (arr_stim_rst_ip) begin
            walk_q <= BIT0;
        end else begin
            walk_q <= walk_d;
        end
    end
`else
    if (SEED == '0) begin : g_seed_chk
        $error("EXM_ERROR: arr_stim SEED must be non-zero");
    end

    arr_stim_lfsr #(
        .OUT_W (LENGTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_i      (arr_stim_clk_ip),
        .rst_i      (arr_stim_rst_ip),
        .load_i     (load),
        .seed_i     (SEED),
        .adv_i      (vec_go),
        .next_pat_o (pattern)
    );
`endif

    // Next-state and output decode. A zero-length run still passes through
    // RUN for one cycle, so done always lands N+1 cycles after the start edge.
    always_comb begin
        state_d  = state_q;
        sig0_d   = sig0_q;
        sig1_d   = sig1_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sent_d   = sent_q;
        count_d  = count_q;
        inject_d = inject_q;
        case (state_q)
            ST_IDLE: begin
                if (arr_stim_start_ip) begin
                    count_d  = arr_stim_count_ip;
                    inject_d = arr_stim_inject_ip;
                    sent_d   = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (vec_go) begin
                    sig0_d = pattern;
                    sig1_d = (vec_n == inject_q) ? (pattern ^ BIT0) : pattern;
                    sent_d = vec_n;
                    busy_d = 1'b1;
                end else begin
                    sig0_d  = '0;
                    sig1_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge arr_stim_clk_ip or posedge arr_stim_rst_ip) begin
        if (arr_stim_rst_ip) begin
            state_q  <= ST_IDLE;
            sig0_q   <= '0;
            sig1_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
            count_q  <= '0;
            inject_q <= '0;
        end else begin
            state_q  <= state_d;
            sig0_q   <= sig0_d;
            sig1_q   <= sig1_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sent_q   <= sent_d;
            count_q  <= count_d;
            inject_q <= inject_d;
        end
    end

    assign arr_stim_sig0_op = sig0_q;
    assign arr_stim_sig1_op = sig1_q;
    assign arr_stim_busy_op = busy_q;
    assign arr_stim_done_op = done_q;
    assign arr_stim_sent_op = sent_q;

endmodule
